// File: rtl/seq_det_pkg.sv
// Shared constants, detector context record and index-width helper for seq_det_sched.
package seq_det_pkg;
  localparam int PLEN_MAX = 16;
  localparam int FILL_W   = 5;

  localparam int                    NCH_DEF     = 4;
  localparam int                    PLEN_DEF    = 4;
  localparam logic [PLEN_MAX-1:0]   PATTERN_DEF = 16'b1010;

  // hist holds the newest PLEN bits right-aligned; bits above PLEN stay zero
  typedef struct packed {
    logic [PLEN_MAX-1:0] hist;
    logic [FILL_W-1:0]   fill;
  } ctx_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_det_engine.sv
// Combinational detector step: shifts one bit into a channel context and flags the accept state.
module seq_det_engine
  import seq_det_pkg::*;
#(
  parameter int              PLEN    = PLEN_DEF,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(PATTERN_DEF)
) (
  input  ctx_t i_ctx,
  input  logic i_bit,
  output ctx_t o_ctx,
  output logic o_acc
);
  localparam int                SW   = PLEN_MAX + 1;
  localparam logic [SW-1:0]     MASK = SW'((33'd1 << PLEN) - 33'd1);

  logic [SW-1:0] w_sh;
  logic          w_unused_msb;

  // oldest bit falls off the top of the PLEN window
  assign w_sh         = {i_ctx.hist, i_bit} & MASK;
  assign w_unused_msb = w_sh[SW-1];

  always_comb begin
    o_ctx      = '0;
    o_ctx.hist = w_sh[PLEN_MAX-1:0];
    o_ctx.fill = (i_ctx.fill >= FILL_W'(PLEN)) ? FILL_W'(PLEN) : i_ctx.fill + 1'b1;
    o_acc      = (w_sh[PLEN-1:0] == PATTERN) && (o_ctx.fill == FILL_W'(PLEN));
  end
endmodule

// File: rtl/seq_det_sched.sv
// Round-robin time-shared Moore sequence detector over NCH serial channels.
// Optional per-channel hit counters under SEQDET_SCHED_STATS_EN.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int              NCH     = NCH_DEF,
  parameter int              PLEN    = PLEN_DEF,
  parameter logic [PLEN-1:0] PATTERN = PLEN'(PATTERN_DEF),
  localparam int             IW      = idx_w(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic [NCH-1:0] bit_in,
  input  logic           clr,
  output logic [NCH-1:0] gnt,
  output logic [NCH-1:0] match,
  output logic           hit,
  output logic [IW-1:0]  hit_ch
`ifdef SEQDET_SCHED_STATS_EN
  ,
  input  logic [IW-1:0]  cnt_sel,
  output logic [7:0]     cnt_out
`endif
);
  logic [IW-1:0]  r_ptr;
  ctx_t           r_ctx [NCH];
  logic [NCH-1:0] r_match;
  logic           r_hit;
  logic [IW-1:0]  r_hit_ch;

  logic           w_any;
  logic [IW-1:0]  w_gidx;
  ctx_t           w_ctx_nxt;
  logic           w_acc;

  // first requester at or after r_ptr, wrapping; clr suppresses the grant
  always_comb begin
    w_any  = 1'b0;
    w_gidx = '0;
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = (int'(r_ptr) + k) % NCH;
      if (!w_any && req[j]) begin
        w_any  = 1'b1;
        w_gidx = IW'(j);
      end
    end
    if (clr) w_any = 1'b0;
    gnt = '0;
    if (w_any) gnt[w_gidx] = 1'b1;
  end

  seq_det_engine #(.PLEN(PLEN), .PATTERN(PATTERN)) u_eng (
    .i_ctx (r_ctx[w_gidx]),
    .i_bit (bit_in[w_gidx]),
    .o_ctx (w_ctx_nxt),
    .o_acc (w_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_match  <= '0;
      r_hit    <= 1'b0;
      r_hit_ch <= '0;
      for (int i = 0; i < NCH; i++) r_ctx[i] <= '0;
    end else if (clr) begin
      r_match <= '0;
      r_hit   <= 1'b0;
      for (int i = 0; i < NCH; i++) r_ctx[i] <= '0;
    end else if (w_any) begin
      r_ctx[w_gidx]   <= w_ctx_nxt;
      r_match[w_gidx] <= w_acc;
      r_hit           <= w_acc;
      r_hit_ch        <= w_gidx;
      r_ptr           <= (w_gidx == IW'(NCH - 1)) ? '0 : w_gidx + 1'b1;
    end else begin
      r_hit <= 1'b0;
    end
  end

  assign match  = r_match;
  assign hit    = r_hit;
  assign hit_ch = r_hit_ch;

`ifdef SEQDET_SCHED_STATS_EN
  logic [7:0] r_cnt [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
    end else if (w_any && w_acc && r_cnt[w_gidx] != 8'hFF) begin
      r_cnt[w_gidx] <= r_cnt[w_gidx] + 8'd1;
    end
  end

  assign cnt_out = r_cnt[cnt_sel];
`endif
endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: spec-level model pushes expected outputs per grant.
module tb_seq_det_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, bit_in, req0, bit0;
  logic       clr;
  logic [3:0] gnt, match, gnt0, match0;
  logic       hit, hit0;
  logic [1:0] hit_ch, hit_ch0;
`ifdef SEQDET_SCHED_STATS_EN
  logic [1:0] cnt_sel, cnt_sel0;
  logic [7:0] cnt_out, cnt_out0;
`endif

  always #5 clk = ~clk;

  seq_det_sched #(.NCH(4), .PLEN(4), .PATTERN(4'b1010)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bit_in(bit_in), .clr(clr),
    .gnt(gnt), .match(match), .hit(hit), .hit_ch(hit_ch)
`ifdef SEQDET_SCHED_STATS_EN
    , .cnt_sel(cnt_sel), .cnt_out(cnt_out)
`endif
  );

  seq_det_sched #(.NCH(4), .PLEN(4), .PATTERN(4'b0000)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .bit_in(bit0), .clr(clr),
    .gnt(gnt0), .match(match0), .hit(hit0), .hit_ch(hit_ch0)
`ifdef SEQDET_SCHED_STATS_EN
    , .cnt_sel(cnt_sel0), .cnt_out(cnt_out0)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // reference model of the 1010 instance
  logic [3:0] pat_v = 4'b1010;
  int         m_ptr;
  logic [3:0] m_hist [4];
  int         m_fill [4];
  logic [3:0] m_match;
  logic       m_hit;
  logic [1:0] m_hitch;
  int         n1;
  int         obs_hits;
  logic [6:0] sb [$];

  task automatic m_reset();
    m_ptr = 0; m_match = '0; m_hit = 1'b0; m_hitch = '0;
    for (int i = 0; i < 4; i++) begin m_hist[i] = '0; m_fill[i] = 0; end
  endtask

  task automatic step(input logic [3:0] rq, input logic [3:0] b, input logic c);
    logic [3:0] eg;
    logic [6:0] e;
    int g;
    @(negedge clk);
    req = rq; bit_in = b; clr = c;
    #1;
    eg = '0; g = -1;
    if (!c)
      for (int k = 0; k < 4; k++)
        if (g < 0 && rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (c) begin
      for (int i = 0; i < 4; i++) begin m_hist[i] = '0; m_fill[i] = 0; end
      m_match = '0; m_hit = 1'b0;
    end else if (g >= 0) begin
      m_hist[g] = {m_hist[g][2:0], b[g]};
      if (m_fill[g] < 4) m_fill[g]++;
      m_hit      = (m_hist[g] == pat_v) && (m_fill[g] == 4);
      m_match[g] = m_hit;
      m_hitch    = 2'(g);
      m_ptr      = (g + 1) % 4;
      if (g == 1) n1++;
    end else begin
      m_hit = 1'b0;
    end
    sb.push_back({m_match, m_hit, m_hitch});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("match", 32'(match), 32'(e[6:3]));
    chk("hit", 32'(hit), 32'(e[2]));
    if (e[2]) chk("hit_ch", 32'(hit_ch), 32'(e[1:0]));
    obs_hits += int'(hit);
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    req = '0; clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    rst_n = 1'b1;
    m_reset();
  endtask

  initial begin
    rst_n = 1'b0; req = '0; bit_in = '0; clr = 1'b0; req0 = '0; bit0 = '0;
`ifdef SEQDET_SCHED_STATS_EN
    cnt_sel = 2'd3; cnt_sel0 = 2'd0;
`endif
    m_reset();
    n1 = 0; obs_hits = 0;
    #12;
    chk("reset_match", 32'(match), 32'd0);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_hit_ch", 32'(hit_ch), 32'd0);
    chk("reset_gnt", 32'(gnt), 32'd0);
    rst_n = 1'b1;

    // channel 0 alone, overlapping 101010
    for (int k = 0; k < 6; k++) step(4'b0001, {3'b0, ~1'(k % 2)}, 1'b0);
    chk("t1_hits", 32'(obs_hits), 32'd2);

    // all four requesting; ch1 fed 1010, others 0
    pulse_rst();
    n1 = 0;
    for (int k = 0; k < 16; k++) step(4'b1111, {2'b0, (n1 < 4) ? pat_v[3 - n1] : 1'b0, 1'b0}, 1'b0);
    chk("t2_n1", 32'(n1), 32'd4);
    chk("t2_match", 32'(match), 32'b0010);

    // fill guard on the all-zeros pattern instance, channel 2
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req0 = 4'b0100; bit0 = 4'b0000;
      #1 chk("z_gnt", 32'(gnt0), 32'b0100);
      @(posedge clk);
      #1;
      chk("z_hit", 32'(hit0), 32'(k == 3));
      if (k == 3) chk("z_hit_ch", 32'(hit_ch0), 32'd2);
    end
    @(negedge clk);
    req0 = '0;

    // clr mid-pattern on ch0
    pulse_rst();
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 1'b0);
    obs_hits = 0;
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    chk("clr_hits", 32'(obs_hits), 32'd1);

    // async reset mid-stream after a hit, then history must refill
    pulse_rst();
    chk("ptr0_gnt_pre", 32'(gnt), 32'd0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b0001, 4'b0001, 1'b0);
    step(4'b0001, 4'b0000, 1'b0);
    step(4'b1010, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b0);

`ifdef SEQDET_SCHED_STATS_EN
    pulse_rst();
    step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b0000, 1'b0);
    for (int k = 0; k < 300; k++) begin
      step(4'b1000, 4'b1000, 1'b0);
      step(4'b1000, 4'b0000, 1'b0);
    end
    cnt_sel = 2'd3;
    #1 chk("cnt_sat", 32'(cnt_out), 32'd255);
    step(4'b0000, 4'b0000, 1'b1);
    chk("cnt_clr", 32'(cnt_out), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
